ssp_tx_sched: RTL

SSP_TX_SCHED -- requirements
Module: ssp_tx_sched

---
 rtl/ssp_tx_sched_if.sv | 31 +++
 rtl/ssp_tx_sched.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ssp_tx_sched_if.sv
// Bundle between the SSP transmit scheduler, its requesters and the serial engine.
// Latency: n/a (wires only).
// Backpressure: n/a; transmit_complete from the engine paces the scheduler.
// Ports: req/req_data/req_en (requesters -> scheduler), gnt/done (scheduler -> requesters),
//        tx_ready/TxData (scheduler -> engine), transmit_complete (engine -> scheduler),
//        err/busy/frame_cnt (status).
interface ssp_tx_sched_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_en;
  logic        transmit_complete;
  logic        tx_ready;
  logic [7:0]  TxData;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        err;
  logic        busy;
  logic [15:0] frame_cnt;

  // Environment side: drives requests and engine status, observes the scheduler.
  modport master (
    output req, req_data, req_en, transmit_complete,
    input  tx_ready, TxData, gnt, done, err, busy, frame_cnt
  );

  // Scheduler side.
  modport slave (
    input  req, req_data, req_en, transmit_complete,
    output tx_ready, TxData, gnt, done, err, busy, frame_cnt
  );
endinterface

// File: rtl/ssp_tx_sched.sv
// Round-robin scheduler feeding one byte per grant from four requesters to the SSP transmit engine.
// Latency: grant, tx_ready and TxData registered one edge after an eligible request is seen in IDLE.
// Backpressure: holds tx_ready until the engine drops transmit_complete (16-cycle timeout), then waits for it to rise.
// Ports: PCLK (clock), CLEAR_B (sync active-low reset), bus (ssp_tx_sched_if.slave).
module ssp_tx_sched (
  input  logic           PCLK,
  input  logic           CLEAR_B,
  ssp_tx_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, START, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  to_cnt_q, to_cnt_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [3:0]  done_q, done_d;
  logic        err_q, err_d;
  logic        tx_ready_q, tx_ready_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic [3:0]  eligible;
  logic        win_vld;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic [1:0]  owner_idx;

  // Round-robin pick. Scanning offsets from high to low lets the smallest
  // offset from ptr overwrite earlier candidates, so ptr, ptr+1, ... wins in order.
  always_comb begin
    eligible = bus.req & bus.req_en;
    win_vld  = 1'b0;
    win_idx  = ptr_q;
    cand     = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (eligible[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // gnt is one-hot while owned; recover the owner index for the pointer update.
  always_comb begin
    case (gnt_q)
      4'b0010: owner_idx = 2'd1;
      4'b0100: owner_idx = 2'd2;
      4'b1000: owner_idx = 2'd3;
      default: owner_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    to_cnt_d    = to_cnt_q;
    gnt_d       = gnt_q;
    done_d      = 4'b0000;
    err_d       = 1'b0;
    tx_ready_d  = tx_ready_q;
    tx_data_d   = tx_data_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d      = 4'b0000;
        tx_ready_d = 1'b0;
        if (win_vld) begin
          state_d    = START;
          gnt_d      = 4'b0001 << win_idx;
          tx_ready_d = 1'b1;
          tx_data_d  = bus.req_data[{win_idx, 3'b000} +: 8];
          to_cnt_d   = 4'd0;
        end
      end
      START: begin
        if (!bus.transmit_complete) begin
          state_d    = SHIFT;
          tx_ready_d = 1'b0;
        end else if (to_cnt_q == 4'hF) begin
          // Engine never started: abandon without touching ptr so the
          // same requester is retried first.
          state_d    = IDLE;
          err_d      = 1'b1;
          gnt_d      = 4'b0000;
          tx_ready_d = 1'b0;
          to_cnt_d   = 4'd0;
        end else begin
          to_cnt_d = to_cnt_q + 4'd1;
        end
      end
      SHIFT: begin
        if (bus.transmit_complete) begin
          state_d = DONE;
          done_d  = gnt_q;   // visible during the DONE cycle
        end
      end
      DONE: begin
        state_d     = IDLE;
        frame_cnt_d = frame_cnt_q + 16'd1;
        ptr_d       = owner_idx + 2'd1;
        gnt_d       = 4'b0000;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      to_cnt_q    <= 4'd0;
      gnt_q       <= 4'b0000;
      done_q      <= 4'b0000;
      err_q       <= 1'b0;
      tx_ready_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      frame_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      to_cnt_q    <= to_cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tx_ready_q  <= tx_ready_d;
      tx_data_q   <= tx_data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.tx_ready  = tx_ready_q;
  assign bus.TxData    = tx_data_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
